spi_master_param: RTL and testbench
===================================

Name: spi_master_param

Overview:
- Parametrised SPI master; next generation of the single-mode, single-CS master_transmisor.
- Adds configurable word width, SCK divider, N one-hot active-low chip selects, and all four CKP/CPH modes latched per transaction.
- Captures a full-duplex receive word and reports completion with a busy/done handshake.
- Drives one or more slave_receptor instances, either in parallel on separate CS lines or daisy-chained on one CS with DATA_W = 8 x chain length.

Parameters:
- DATA_W, 8, bits per transaction, MSB first, >= 2.
- CLK_DIV, 2, CLK cycles per SCK half-period, >= 1.
- N_SLAVES, 4, number of CS outputs, >= 1.
- SEL_W, 2, width of slave_sel, >= 1, with 2^SEL_W >= N_SLAVES.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- start_transaction  input  1  level request; sampled only in IDLE.
- CKP  input  1  SCK idle level; latched at start.
- CPH  input  1  clock phase; latched at start.
- slave_sel  input  SEL_W  target CS index; latched at start.
- tx_data  input  DATA_W  word to transmit; latched at start.
- MISO  input  1  serial data in.
- MOSI  output  1  serial data out.
- SCK  output  1  serial clock.
- CS  output  N_SLAVES  active-low chip selects, at most one low.
- rx_data  output  DATA_W  last received word.
- busy  output  1  high from CS assertion through the last HOLD cycle.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (Reset=0, asynchronous, any state):
  - State IDLE; SCK=0, MOSI=0, CS all 1s, busy=0, done=0, rx_data=0.
  - Shift registers and counters are cleared.
  - An in-flight transfer aborts with no done and rx_data unchanged from 0.
- States:
  - IDLE: SCK <= CKP (live input) every cycle; MOSI=0.
    - If start_transaction=1 and slave_sel < N_SLAVES: latch tx_data, CKP, CPH, slave_sel. Next cycle CS[slave_sel]=0, busy=1, go to SETUP.
    - If start_transaction=1 and slave_sel >= N_SLAVES: request ignored; no CS, busy or done activity.
  - SETUP: CLK_DIV cycles. SCK holds latched CKP.
    - CPH=0: MOSI = tx bit DATA_W-1 from the first SETUP cycle.
    - CPH=1: MOSI holds 0 until the first edge.
  - TRANSFER: SCK toggles every CLK_DIV cycles, for exactly 2*DATA_W edges. The leading edge of each bit is idle->active; the trailing edge is active->idle.
    - CPH=0: sample MISO on the leading edge; shift the next bit onto MOSI on the trailing edge. No shift after the final trailing edge.
    - CPH=1: shift the next bit onto MOSI on the leading edge (the first leading edge drives the MSB); sample MISO on the trailing edge.
    - Received bits shift in MSB first.
  - HOLD: CLK_DIV cycles; SCK at idle level, MOSI holds the last bit.
    - At exit: CS all 1s, busy=0, rx_data <= received word, done=1 for exactly one cycle, go to IDLE.
- Timing:
  - CS low for exactly (2*DATA_W+2)*CLK_DIV cycles.
  - If start is sampled at edge k, done is high in cycle k+1+(2*DATA_W+2)*CLK_DIV.
  - Inter-transaction gap: a start sampled in the done cycle is accepted; CS stays high at least 1 cycle between transactions.
- Latching and handshake:
  - Changes to CKP, CPH, slave_sel, tx_data while busy=1 have no effect on the current transfer.
  - start_transaction is level-sensitive: held high, it re-triggers back-to-back transactions.
- rx_data changes only in the done cycle.
- SCK never glitches: it changes at most once per CLK_DIV cycles and only from a registered output.

Test Plan:
- Mode 0 loopback (MISO tied to MOSI), DATA_W=8, CLK_DIV=2, tx=0xA5, sel=0 -> CS=4'b1110 for 36 cycles; 8 rising SCK edges; done in cycle k+37; rx_data=0xA5; busy falls with done.
- Mode 3 (CKP=1, CPH=1), tx=0x3C, sel=2, MISO driven by a model returning 0xC3 -> SCK idles high; CS=4'b1011; MOSI stream 0,0,1,1,1,1,0,0; rx_data=0xC3.
- Modes 1 and 2, tx=0x81 loopback -> rx_data=0x81 in both modes; sampling occurs on the trailing edge for CPH=1 and the leading edge for CPH=0.
- Three slave_receptor instances daisy-chained on CS[0], DATA_W=24, tx=0x123456; run twice -> second rx_data equals the first tx word shifted through the chain (0x123456).
- Reset pulled low mid-TRANSFER after 5 SCK edges -> same-cycle CS=4'hF, SCK=0, busy=0, no done, rx_data=0; a new start after release completes normally.
- slave_sel=5 with N_SLAVES=4 and start held 10 cycles -> CS stays 4'hF, busy=0, done never asserted; changing tx_data mid-transfer leaves the transmitted word unchanged.

Source files
------------

// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable width, SCK divider, one-hot active-low CS,
// all four CKP/CPH modes latched per transaction, full-duplex receive with busy/done.
module spi_master_param #(
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 2,
  parameter int N_SLAVES = 4,
  parameter int SEL_W    = 2
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                start_transaction,
  input  logic                CKP,
  input  logic                CPH,
  input  logic [SEL_W-1:0]    slave_sel,
  input  logic [DATA_W-1:0]   tx_data,
  input  logic                MISO,
  output logic                MOSI,
  output logic                SCK,
  output logic [N_SLAVES-1:0] CS,
  output logic [DATA_W-1:0]   rx_data,
  output logic                busy,
  output logic                done
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [EDGE_W-1:0]     edge_q, edge_d;
  logic [DATA_W-1:0]     tx_q, tx_d;
  logic [DATA_W-1:0]     rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]     rx_q, rx_d;
  logic [N_SLAVES-1:0]   cs_q, cs_d;
  logic                  ckp_q, ckp_d, cph_q, cph_d;
  logic                  sck_q, sck_d, mosi_q, mosi_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [N_SLAVES-1:0]   sel_hot;
  logic                  sel_ok, div_end, leading;

  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_sel
    assign sel_hot[gi] = (slave_sel == SEL_W'(gi));
  end

  // An out-of-range select decodes to no line at all, so the request is dropped.
  assign sel_ok  = |sel_hot;
  assign div_end = (div_q == DIV_LAST);
  assign leading = ~edge_q[0];

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      cs_q    <= '1;
      ckp_q   <= 1'b0;
      cph_q   <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      cs_q    <= cs_d;
      ckp_q   <= ckp_d;
      cph_q   <= cph_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    cs_d    = cs_q;
    ckp_d   = ckp_q;
    cph_d   = cph_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        sck_d  = CKP;
        mosi_d = 1'b0;
        div_d  = '0;
        edge_d = '0;
        if (start_transaction && sel_ok) begin
          ckp_d   = CKP;
          cph_d   = CPH;
          cs_d    = ~sel_hot;
          busy_d  = 1'b1;
          rx_sh_d = '0;
          // CPH=0 presents the MSB before the first edge; CPH=1 drives it on the first leading edge.
          if (CPH) begin
            tx_d = tx_data;
          end else begin
            tx_d   = tx_data << 1;
            mosi_d = tx_data[DATA_W-1];
          end
          state_d = SETUP;
        end
      end

      SETUP: begin
        sck_d = ckp_q;
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) state_d = TRANSFER;
      end

      TRANSFER: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          sck_d  = ~sck_q;
          edge_d = edge_q + 1'b1;
          // Sample edge is the leading one for CPH=0 and the trailing one for CPH=1.
          if (leading ^ cph_q) begin
            rx_sh_d = {rx_sh_q[DATA_W-2:0], MISO};
          end else if (edge_q != EDGE_LAST) begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = tx_q << 1;
          end
          if (edge_q == EDGE_LAST) begin
            edge_d  = '0;
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        sck_d = ckp_q;
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          cs_d    = '1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rx_d    = rx_sh_q;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign MOSI    = mosi_q;
  assign SCK     = sck_q;
  assign CS      = cs_q;
  assign rx_data = rx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: vector table, randomized transfers against a behavioural
// SPI slave, back-to-back, invalid select, mid-transfer reset and a 24-bit daisy chain.
module tb_spi_master_param;

  logic       CLK;
  logic       Reset;
  logic       start, ckp, cph, miso;
  logic [2:0] sel;
  logic [7:0] tx;
  logic       mosi, sck, busy, done;
  logic [3:0] cs;
  logic [7:0] rx;

  logic        start24;
  logic [23:0] tx24;
  logic        miso24, mosi24, sck24, busy24, done24;
  logic [3:0]  cs24;
  logic [23:0] rx24;

  int n_tests = 0;
  int n_fail  = 0;

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .N_SLAVES(4), .SEL_W(3)) dut (
    .CLK(CLK), .Reset(Reset), .start_transaction(start), .CKP(ckp), .CPH(cph),
    .slave_sel(sel), .tx_data(tx), .MISO(miso), .MOSI(mosi), .SCK(sck), .CS(cs),
    .rx_data(rx), .busy(busy), .done(done)
  );

  spi_master_param #(.DATA_W(24), .CLK_DIV(2), .N_SLAVES(4), .SEL_W(2)) dut24 (
    .CLK(CLK), .Reset(Reset), .start_transaction(start24), .CKP(1'b0), .CPH(1'b0),
    .slave_sel(2'd0), .tx_data(tx24), .MISO(miso24), .MOSI(mosi24), .SCK(sck24), .CS(cs24),
    .rx_data(rx24), .busy(busy24), .done(done24)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural slave for the 8-bit master: returns s_word, captures MOSI into s_cap.
  logic       m_ckp = 1'b0, m_cph = 1'b0, loopback = 1'b0;
  logic [7:0] s_word = '0, s_cap = '0;
  logic       s_miso = 1'b0, cs_prev = 1'b0, sck_prev = 1'b0;
  int         s_idx = 0;
  logic       cs_act;
  assign cs_act = ~&cs;
  assign miso   = loopback ? mosi : s_miso;

  always @(cs_act or sck) begin
    if (cs_act && !cs_prev) begin
      s_cap = '0;
      if (m_cph) begin
        s_miso = 1'b0;
        s_idx  = 7;
      end else begin
        s_miso = s_word[7];
        s_idx  = 6;
      end
    end else if (cs_act && (sck !== sck_prev)) begin
      if ((sck != m_ckp) ^ m_cph) begin
        s_cap = {s_cap[6:0], mosi};
      end else if (s_idx >= 0) begin
        s_miso = s_word[s_idx];
        s_idx  = s_idx - 1;
      end
    end
    cs_prev  = cs_act;
    sck_prev = sck;
  end

  // Three 8-bit mode-0 shift stages in series behave as one 24-bit register.
  logic [23:0] chain = '0;
  logic        cap24 = 1'b0;
  always @(posedge sck24) if (!cs24[0]) cap24 = mosi24;
  always @(negedge sck24) if (!cs24[0]) chain = {chain[22:0], cap24};
  assign miso24 = chain[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input logic c_ckp, input logic c_cph, input logic [2:0] c_sel,
                         input logic [7:0] c_tx, input logic [7:0] c_word, input logic c_loop,
                         input logic [3:0] exp_cs, input logic [7:0] exp_rx);
    int n, cs_low, cs_bad, lead, rx_moves, done_at;
    logic prev_sck;
    logic [7:0] rx_prev;
    @(negedge CLK);
    ckp = c_ckp; cph = c_cph; sel = c_sel; tx = c_tx; loopback = c_loop;
    m_ckp = c_ckp; m_cph = c_cph; s_word = c_word;
    @(negedge CLK);
    @(negedge CLK);
    chk("idle_sck", sck, c_ckp);
    start = 1'b1;
    prev_sck = sck; rx_prev = rx;
    n = 0; cs_low = 0; cs_bad = 0; lead = 0; rx_moves = 0; done_at = 0;
    while (done_at == 0 && n < 200) begin
      @(negedge CLK);
      n++;
      if (n == 1) start = 1'b0;
      if (n == 10) begin
        ckp = ~c_ckp; cph = ~c_cph; tx = ~c_tx; sel = 3'($urandom_range(0, 3));
      end
      if (cs != 4'hF) begin
        cs_low++;
        if (cs !== exp_cs) cs_bad++;
      end
      if (sck !== prev_sck && sck !== c_ckp) lead++;
      prev_sck = sck;
      if (done) done_at = n;
      else if (rx !== rx_prev) rx_moves++;
    end
    chk("done_latency", done_at, 37);
    chk("cs_low_cycles", cs_low, 36);
    chk("cs_pattern_errors", cs_bad, 0);
    chk("leading_edges", lead, 8);
    chk("rx_data", rx, exp_rx);
    chk("rx_early_change", rx_moves, 0);
    chk("mosi_stream", s_cap, c_tx);
    chk("busy_at_done", busy, 0);
    chk("cs_at_done", cs, 4'hF);
    $display("[TB] txn ckp=%0d cph=%0d sel=%0d tx=%02h loop=%0d rx=%02h exp=%02h done_at=%0d",
             c_ckp, c_cph, c_sel, c_tx, c_loop, rx, exp_rx, done_at);
    @(negedge CLK);
    chk("done_pulse_width", done, 0);
  endtask

  typedef struct {
    logic       ckp;
    logic       cph;
    logic [2:0] sel;
    logic [7:0] tx;
    logic [7:0] word;
    logic       loopback;
    logic [3:0] exp_cs;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       r_ckp, r_cph, r_loop;
    logic [2:0] r_sel;
    logic [7:0] r_tx, r_word, e_rx;
    logic [3:0] e_cs;
    int         n, edges, bad;
    logic       psck;

    vecs[0] = '{1'b0, 1'b0, 3'd0, 8'hA5, 8'h00, 1'b1, 4'b1110, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 3'd2, 8'h3C, 8'hC3, 1'b0, 4'b1011, 8'hC3};
    vecs[2] = '{1'b0, 1'b1, 3'd1, 8'h81, 8'h00, 1'b1, 4'b1101, 8'h81};
    vecs[3] = '{1'b1, 1'b0, 3'd3, 8'h81, 8'h00, 1'b1, 4'b0111, 8'h81};

    Reset = 1'b0; start = 1'b0; ckp = 1'b0; cph = 1'b0; sel = '0; tx = '0;
    start24 = 1'b0; tx24 = '0;
    repeat (3) @(negedge CLK);
    chk("reset_cs", cs, 4'hF);
    chk("reset_sck", sck, 0);
    chk("reset_mosi", mosi, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rx", rx, 0);
    chk("reset_cs24", cs24, 4'hF);
    Reset = 1'b1;

    for (int i = 0; i < 4; i++)
      run_txn(vecs[i].ckp, vecs[i].cph, vecs[i].sel, vecs[i].tx, vecs[i].word,
              vecs[i].loopback, vecs[i].exp_cs, vecs[i].exp_rx);

    for (int i = 0; i < 20; i++) begin
      r_ckp  = 1'($urandom_range(0, 1));
      r_cph  = 1'($urandom_range(0, 1));
      r_loop = 1'($urandom_range(0, 1));
      r_sel  = 3'($urandom_range(0, 3));
      r_tx   = 8'($urandom);
      r_word = 8'($urandom);
      e_cs   = ~(4'b0001 << r_sel);
      e_rx   = r_loop ? r_tx : r_word;
      run_txn(r_ckp, r_cph, r_sel, r_tx, r_word, r_loop, e_cs, e_rx);
    end

    // Start held high: accepted again in the done cycle, CS high for exactly that cycle.
    @(negedge CLK);
    ckp = 1'b0; cph = 1'b0; sel = 3'd0; tx = 8'h55; loopback = 1'b1; m_ckp = 1'b0; m_cph = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    start = 1'b1;
    n = 0;
    while (!done && n < 200) begin @(negedge CLK); n++; end
    chk("b2b_first_done", n, 37);
    chk("b2b_gap_cs", cs, 4'hF);
    @(negedge CLK);
    chk("b2b_restart_cs", cs, 4'b1110);
    chk("b2b_restart_busy", busy, 1);
    start = 1'b0;
    n = 0;
    while (!done && n < 200) begin @(negedge CLK); n++; end
    chk("b2b_second_done", n, 36);
    chk("b2b_rx", rx, 8'h55);
    $display("[TB] txn back-to-back rx=%02h", rx);

    // Out-of-range select is ignored.
    @(negedge CLK);
    sel = 3'd5; tx = 8'hEE; start = 1'b1; bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (cs !== 4'hF || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    start = 1'b0;
    chk("bad_sel_activity", bad, 0);
    $display("[TB] txn sel=5 ignored, bad_cycles=%0d", bad);

    // Reset in the middle of TRANSFER.
    @(negedge CLK);
    ckp = 1'b0; cph = 1'b0; sel = 3'd1; tx = 8'hF0; loopback = 1'b0; m_ckp = 1'b0; m_cph = 1'b0;
    s_word = 8'h0F;
    @(negedge CLK);
    @(negedge CLK);
    start = 1'b1; psck = sck; edges = 0; n = 0;
    while (edges < 5 && n < 100) begin
      @(negedge CLK);
      n++;
      start = 1'b0;
      if (sck !== psck) edges++;
      psck = sck;
    end
    chk("abort_edges_reached", edges, 5);
    #2 Reset = 1'b0;
    #1;
    chk("abort_cs", cs, 4'hF);
    chk("abort_sck", sck, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rx", rx, 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (done !== 1'b0) bad++;
    end
    chk("abort_no_done", bad, 0);
    Reset = 1'b1;
    $display("[TB] txn reset abort after %0d edges", edges);
    run_txn(1'b0, 1'b0, 3'd1, 8'h96, 8'h69, 1'b0, 4'b1101, 8'h69);

    // 24-bit daisy chain: second pass returns the first word.
    for (int r = 0; r < 2; r++) begin
      @(negedge CLK);
      tx24 = 24'h123456; start24 = 1'b1; n = 0;
      while (!done24 && n < 300) begin
        @(negedge CLK);
        n++;
        if (n == 1) begin start24 = 1'b0; tx24 = 24'hFFFFFF; end
      end
      chk("chain_latency", n, 101);
      chk("chain_rx", rx24, (r == 0) ? 32'h0 : 32'h123456);
      $display("[TB] txn chain pass %0d rx=%06h", r, rx24);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
